// File: rtl/ifetch_bp.sv
// Instruction fetch unit with a 2-bit-counter branch history table.
// Presents the fetch PC to the ICache, pushes one instruction per cycle to the
// IQueue with a predicted next PC, stalls on JALR until the resolved target
// arrives, and stops on the halt encoding until redirected.
module ifetch_bp #(
  parameter int          BHT_IDX_W = 6,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] HALT_INST = 32'h0ff00513
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  output logic [31:0] ic_pc,
  input  logic        ic_hit,
  input  logic [31:0] ic_inst,
  input  logic        iq_full,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_pred_pc,
  output logic        iq_pred_taken,
  input  logic        br_valid,
  input  logic        br_is_cond,
  input  logic [31:0] br_pc,
  input  logic        br_taken,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  output logic        halted
);

  localparam int         BHT_N     = 1 << BHT_IDX_W;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_FETCH, S_WAIT_JALR, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        iq_valid_q, iq_valid_d;
  logic [31:0] iq_inst_q, iq_inst_d;
  logic [31:0] iq_pc_q, iq_pc_d;
  logic [31:0] iq_pred_pc_q, iq_pred_pc_d;
  logic        iq_pred_taken_q, iq_pred_taken_d;
  logic        halted_q, halted_d;
  logic [1:0]  bht_q [BHT_N];
  logic [1:0]  bht_d [BHT_N];

  logic                 fire;
  logic                 is_halt;
  logic [6:0]           opcode;
  logic [31:0]          j_imm;
  logic [31:0]          b_imm;
  logic [31:0]          pred_pc;
  logic                 pred_taken;
  logic [BHT_IDX_W-1:0] lookup_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 unused_br_pc_bits;

  assign opcode     = ic_inst[6:0];
  assign is_halt    = (ic_inst == HALT_INST);
  assign j_imm      = {{11{ic_inst[31]}}, ic_inst[31], ic_inst[19:12], ic_inst[20],
                       ic_inst[30:21], 1'b0};
  assign b_imm      = {{19{ic_inst[31]}}, ic_inst[31], ic_inst[7], ic_inst[30:25],
                       ic_inst[11:8], 1'b0};
  assign lookup_idx = pc_q[BHT_IDX_W+1:2];
  assign upd_idx    = br_pc[BHT_IDX_W+1:2];
  assign unused_br_pc_bits = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0]};

  assign ic_pc         = pc_q;
  assign iq_valid      = iq_valid_q;
  assign iq_inst       = iq_inst_q;
  assign iq_pc         = iq_pc_q;
  assign iq_pred_pc    = iq_pred_pc_q;
  assign iq_pred_taken = iq_pred_taken_q;
  assign halted        = halted_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state: a redirect always restarts fetch; JALR and halt leave FETCH.
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      if (br_redirect)                 state_d = S_FETCH;
      else if (fire && is_halt)        state_d = S_HALT;
      else if (fire && opcode == OP_JALR) state_d = S_WAIT_JALR;
    end
  end

  // State-derived control: a push happens only while fetching and unblocked.
  always_comb begin
    fire = rdy && (state_q == S_FETCH) && ic_hit && !iq_full && !br_redirect;
  end

  // Next-PC prediction; the BHT is read before this cycle's update lands.
  always_comb begin
    pred_pc    = pc_q + 32'd4;
    pred_taken = 1'b0;
    case (opcode)
      OP_JAL: pred_pc = pc_q + j_imm;
      OP_BRANCH: begin
        if (bht_q[lookup_idx][1]) begin
          pred_pc    = pc_q + b_imm;
          pred_taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath next values: redirect beats push, everything holds while !rdy.
  always_comb begin
    pc_d            = pc_q;
    iq_valid_d      = iq_valid_q;
    iq_inst_d       = iq_inst_q;
    iq_pc_d         = iq_pc_q;
    iq_pred_pc_d    = iq_pred_pc_q;
    iq_pred_taken_d = iq_pred_taken_q;
    halted_d        = halted_q;
    if (rdy) begin
      iq_valid_d = 1'b0;
      if (br_redirect) begin
        pc_d     = br_target;
        halted_d = 1'b0;
      end else if (fire) begin
        iq_valid_d      = 1'b1;
        iq_inst_d       = ic_inst;
        iq_pc_d         = pc_q;
        iq_pred_pc_d    = pred_pc;
        iq_pred_taken_d = pred_taken;
        if (is_halt) halted_d = 1'b1;   // halt keeps the PC parked on itself
        else         pc_d     = pred_pc;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      iq_valid_q      <= 1'b0;
      iq_inst_q       <= 32'h0;
      iq_pc_q         <= 32'h0;
      iq_pred_pc_q    <= 32'h0;
      iq_pred_taken_q <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      iq_valid_q      <= iq_valid_d;
      iq_inst_q       <= iq_inst_d;
      iq_pc_q         <= iq_pc_d;
      iq_pred_pc_q    <= iq_pred_pc_d;
      iq_pred_taken_q <= iq_pred_taken_d;
      halted_q        <= halted_d;
    end
  end

  // Saturating counter update for resolved conditional branches.
  always_comb begin
    bht_d = bht_q;
    if (rdy && br_valid && br_is_cond) begin
      if (br_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
    end
  end

  // BHT storage; every counter starts weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

endmodule

// File: doc/ifetch_bp.md
IFETCH_BP -- requirements
Module: ifetch_bp

Interface
REQ-001 Parameter BHT_IDX_W, default 6, SHALL set the BHT index width (2^BHT_IDX_W entries of 2-bit counters).
REQ-002 Parameter RESET_PC, default 32'h0, SHALL set the fetch PC after reset.
REQ-003 Parameter HALT_INST, default 32'h0ff00513, SHALL set the encoding that halts fetch.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rdy  in  1  global enable; when low, all state SHALL hold (including BHT).
REQ-007 ic_pc  out  32  current fetch PC presented to ICache.
REQ-008 ic_hit  in  1  ic_inst valid for ic_pc this cycle.
REQ-009 ic_inst  in  32  instruction word at ic_pc.
REQ-010 iq_full  in  1  IQueue cannot accept this cycle.
REQ-011 iq_valid  out  1  registered; one instruction pushed to IQueue.
REQ-012 iq_inst / iq_pc / iq_pred_pc  out  32 each  instruction, its PC, predicted next PC.
REQ-013 iq_pred_taken  out  1  prediction bit for conditional branches, 0 otherwise.
REQ-014 br_valid  in  1  a branch or JALR resolved this cycle.
REQ-015 br_is_cond  in  1  resolved instruction is a conditional branch (BHT update).
REQ-016 br_pc  in  32  PC of resolved instruction.
REQ-017 br_taken  in  1  actual outcome.
REQ-018 br_redirect  in  1  misprediction or JALR resolution; fetch restarts at br_target.
REQ-019 br_target  in  32  correct next PC.
REQ-020 halted  out  1  HALT state indicator.

Function
REQ-021 States SHALL be FETCH, WAIT_JALR, HALT; encoding is free.
REQ-022 Fire condition: rdy && state==FETCH && ic_hit && !iq_full && !br_redirect.
REQ-023 On fire: iq_valid<=1, iq_inst<=ic_inst, iq_pc<=ic_pc, iq_pred_pc<=next PC chosen below; otherwise iq_valid<=0 (when rdy high).
REQ-024 Next PC, JAL (opcode 1101111): pc + sign-extended J-immediate; iq_pred_taken=0.
REQ-025 Next PC, conditional branch (1100011): if BHT[pc[BHT_IDX_W+1:2]][1] then pc + sign-extended B-immediate with iq_pred_taken=1, else pc+4 with iq_pred_taken=0.
REQ-026 JALR (1100111): pc<=pc+4, iq_pred_pc=pc+4, state->WAIT_JALR; no further fire until br_redirect.
REQ-027 ic_inst==HALT_INST: instruction SHALL still be pushed, state->HALT, halted<=1, pc held.
REQ-028 All other opcodes: pc<=pc+4.
REQ-029 PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFC+4 wraps to 0).
REQ-030 br_redirect (with rdy) SHALL have priority over fire in any state: pc<=br_target, iq_valid<=0, state->FETCH, halted<=0.
REQ-031 BHT update on rdy && br_valid && br_is_cond: counter at br_pc[BHT_IDX_W+1:2] saturating +1 if br_taken, -1 otherwise (bounds 0 and 3).
REQ-032 Same-cycle lookup and update of one index: lookup SHALL use the pre-update value.
REQ-033 iq_full high or ic_hit low: pc and state hold, iq_valid<=0.

Reset
REQ-034 rst_n low SHALL immediately force pc=RESET_PC, state=FETCH, iq_valid=0, iq_pred_taken=0, halted=0, iq_inst/iq_pc/iq_pred_pc=0, every BHT counter=2'b01.
REQ-035 Reset mid-WAIT_JALR or mid-HALT SHALL drop any pending state; first fire allowed on the first posedge after rst_n rises.

Verification
REQ-036 Reset, ic_hit=1, ADDI stream -> iq_pc 0,4,8 on consecutive cycles, iq_valid=1 each.
REQ-037 BEQ at 0x10 with imm=+0x20, fresh BHT -> iq_pred_taken=0, next pc 0x14; after two br_taken=1 updates on 0x10, refetch -> pred_pc 0x30.
REQ-038 JALR at 0x8 -> one push, then no iq_valid until br_redirect with br_target=0x100; next push has iq_pc=0x100.
REQ-039 iq_full held 3 cycles during a stream -> iq_valid=0 those cycles, pc unchanged, no instruction lost or duplicated.
REQ-040 HALT_INST at 0x40 -> pushed once, halted=1, no pushes for 10 cycles; br_redirect to 0x0 resumes fetch at 0x0.
REQ-041 br_redirect same cycle as fire of a JAL -> pc=br_target, iq_valid=0; rdy low 5 cycles -> all outputs and BHT frozen.
